seq_subtractor_64: RTL and testbench

Multi-cycle 64-bit two's-complement subtractor computing `a - b - borrow_in` one 4-bit slice per clock, LSB slice first. It complements the ripple-carry adder datapath as the subtraction path of the 64-bit arithmetic set. It exchanges operands and results over valid/ready handshakes and reports borrow, signed overflow and zero.

---
 rtl/arith_pkg.sv | 23 ++
 rtl/nibble_add4.sv | 18 +
 rtl/seq_subtractor_64.sv | 131 +++++++++++++
 tb/tb_seq_subtractor_64.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the 64-bit arithmetic set.
//   ARITH_WIDTH / ARITH_SLICE : default operand width and bits handled per cycle
//   sub_state_t               : sequential subtractor control states
//   slice_cnt_w()             : width of a counter that indexes WIDTH/SLICE slices
package arith_pkg;

   localparam int ARITH_WIDTH = 64;
   localparam int ARITH_SLICE = 4;

   typedef enum logic [1:0] {
      SUB_IDLE = 2'd0,
      SUB_RUN  = 2'd1,
      SUB_DONE = 2'd2
   } sub_state_t;

   // A single-slice configuration still needs a 1-bit counter.
   function automatic int slice_cnt_w(input int width, input int slice);
      int n;
      n = width / slice;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational SLICE-bit adder with carry in and carry out.
//   a, b : SLICE-bit addends
//   cin  : carry into bit 0
//   sum  : SLICE-bit sum
//   cout : carry out of the top bit
module nibble_add4 #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};

endmodule

// File: rtl/seq_subtractor_64.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, one SLICE-bit slice per
// clock, least significant slice first, via a + ~b + ~borrow_in.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, borrow_in       : minuend, subtrahend, borrow into the LSB
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   diff                  : a - b - borrow_in mod 2^WIDTH
//   borrow_out            : unsigned a < b + borrow_in
//   ovf                   : signed overflow
//   zero                  : diff == 0
module seq_subtractor_64
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH,
   parameter int SLICE = ARITH_SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = slice_cnt_w(WIDTH, SLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   sub_state_t state, state_next;

   // Working operands shift right one slice per RUN cycle so the adder
   // always sees the current slice in the low bits.
   logic [WIDTH-1:0] a_work;
   logic [WIDTH-1:0] nb_work;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             a_msb;
   logic             b_msb;

   logic [SLICE-1:0] sum;
   logic             c_out;
   logic [WIDTH-1:0] diff_next;
   logic             last;

   nibble_add4 #(.SLICE(SLICE)) u_add (
      .a   (a_work[SLICE-1:0]),
      .b   (nb_work[SLICE-1:0]),
      .cin (carry),
      .sum (sum),
      .cout(c_out)
   );

   assign in_ready  = (state == SUB_IDLE);
   assign out_valid = (state == SUB_DONE);
   assign last      = (cnt == LAST);

   // diff with the current slice filled in; used so zero sees the final slice.
   always_comb begin
      diff_next = diff;
      diff_next[cnt*SLICE +: SLICE] = sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SUB_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         SUB_IDLE: if (in_valid)  state_next = SUB_RUN;
         SUB_RUN:  if (last)      state_next = SUB_DONE;
         SUB_DONE: if (out_ready) state_next = SUB_IDLE;
         default:                 state_next = SUB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_work     <= '0;
         nb_work    <= '0;
         carry      <= 1'b0;
         cnt        <= '0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
         zero       <= 1'b0;
      end else begin
         case (state)
            SUB_IDLE: begin
               if (in_valid) begin
                  a_work     <= a;
                  nb_work    <= ~b;
                  carry      <= ~borrow_in;
                  cnt        <= '0;
                  diff       <= '0;
                  a_msb      <= a[WIDTH-1];
                  b_msb      <= b[WIDTH-1];
                  borrow_out <= 1'b0;
                  ovf        <= 1'b0;
                  zero       <= 1'b0;
               end
            end
            SUB_RUN: begin
               a_work  <= a_work >> SLICE;
               nb_work <= nb_work >> SLICE;
               carry   <= c_out;
               cnt     <= cnt + 1'b1;
               diff    <= diff_next;
               if (last) begin
                  // No carry out of the MSB in a + ~b + ~bin means a borrow.
                  borrow_out <= ~c_out;
                  ovf        <= (a_msb != b_msb) && (sum[SLICE-1] != a_msb);
                  zero       <= (diff_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_subtractor_64.sv
module tb_seq_subtractor_64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        borrow_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] diff;
   logic        borrow_out;
   logic        ovf;
   logic        zero;

   seq_subtractor_64 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .borrow_in (borrow_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow_out(borrow_out),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] d;
      logic        bo;
      logic        ov;
      logic        z;
      int          acc;
   } exp_t;

   exp_t q[$];
   exp_t last_exp;
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // Reference: plain wide arithmetic, unsigned and signed views.
   function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic bin);
      exp_t e;
      logic [65:0]        u;
      logic signed [65:0] s;
      u = {2'b00, x} - {2'b00, y} - {65'd0, bin};
      s = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, bin});
      e.d   = u[63:0];
      e.bo  = u[65];
      e.ov  = (s < -(66'sd1 <<< 63)) || (s > ((66'sd1 <<< 63) - 66'sd1));
      e.z   = (u[63:0] == 64'd0);
      e.acc = 0;
      return e;
   endfunction

   // Monitor: one comparison set per result presentation.
   logic prev_ov = 1'b0;
   always @(negedge clk) begin
      if (out_valid && !prev_ov) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("diff", diff, e.d);
            chk("borrow_out", {63'd0, borrow_out}, {63'd0, e.bo});
            chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
            chk("zero", {63'd0, zero}, {63'd0, e.z});
            chk("latency", 64'(cyc - e.acc), 64'd16);
         end
      end
      prev_ov = out_valid;
   end

   task automatic start_op(input logic [63:0] x, input logic [63:0] y, input logic bin);
      exp_t e;
      int   n;
      n = 0;
      while (!in_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
      a = x; b = y; borrow_in = bin; in_valid = 1'b1;
      e = model(x, y, bin);
      @(posedge clk);
      #1;
      e.acc = cyc;
      q.push_back(e);
      last_exp = e;
      in_valid = 1'b0;
      // Operand changes while running must not matter.
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      borrow_in = 1'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 64'(q.size()), 64'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_diff", diff, 64'd0);
      chk("rst_flags", {61'd0, borrow_out, ovf, zero}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      start_op(64'd10, 64'd3, 1'b0);
      @(negedge clk);
      chk("run_in_ready", {63'd0, in_ready}, 64'd0);
      wait_drain();
      start_op(64'd0, 64'd1, 1'b0);                     wait_drain();
      start_op(64'h8000_0000_0000_0000, 64'd1, 1'b0);   wait_drain();
      start_op(64'd5, 64'd4, 1'b1);                     wait_drain();
      start_op(64'h0F, 64'h10, 1'b0);                   wait_drain();
      start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); wait_drain();

      // Random operands, some with shared slices to exercise zero/borrow chains
      for (int i = 0; i < 24; i++) begin
         logic [63:0] x, y;
         x = {$urandom, $urandom};
         y = (i % 4 == 0) ? x : {$urandom, $urandom};
         start_op(x, y, 1'($urandom));
         wait_drain();
      end

      // Backpressure
      out_ready = 1'b0;
      start_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("bp_reach_done", {63'd0, out_valid}, 64'd1);
      end
      for (int i = 0; i < 10; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         in_valid = 1'(i & 1);
         @(negedge clk);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_diff", diff, last_exp.d);
         chk("bp_flags", {61'd0, borrow_out, ovf, zero}, {61'd0, last_exp.bo, last_exp.ov, last_exp.z});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
      chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
      start_op(64'd100, 64'd58, 1'b0);
      wait_drain();

      // Asynchronous reset during slice 8
      start_op(64'hDEAD_BEEF_0000_0001, 64'h1111, 1'b0);
      repeat (8) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_diff", diff, 64'd0);
      chk("arst_flags", {61'd0, borrow_out, ovf, zero}, 64'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_no_result", {63'd0, out_valid}, 64'd0);
      start_op(64'd1, 64'd1, 1'b0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
